// File: rtl/key_store_pkg.sv
// key_store_pkg: key-length codes, length helpers and zeroize FSM states shared by the key store.
package key_store_pkg;
   localparam logic [1:0] KLEN_128 = 2'd0;
   localparam logic [1:0] KLEN_192 = 2'd1;
   localparam logic [1:0] KLEN_256 = 2'd2;
   typedef enum logic {ST_IDLE, ST_ZERO} state_t;
   function automatic int klen_words(input logic [1:0] len);
      return 4 + 2 * int'(len);
   endfunction
   function automatic logic klen_legal(input logic [1:0] len, input int words);
      return len != 2'd3 && klen_words(len) <= words;
   endfunction
endpackage

// File: rtl/key_slot.sv
// key_slot: one key slot holding words, written-word mask, length code and lock, with a derived valid flag.
module key_slot import key_store_pkg::*; #(
   parameter int WORDS = 8,
   parameter int WORD_SIZE = 32,
   parameter logic [1:0] DEFAULT_LEN = KLEN_256,
   localparam int IW = $clog2(WORDS)
) (
   input logic clk,
   input logic rst,
   input logic wen,
   input logic [IW-1:0] widx,
   input logic [WORD_SIZE-1:0] wdata,
   input logic cfg_wen,
   input logic [1:0] cfg_len,
   input logic lock,
   input logic clr_mask,
   input logic clr_wen,
   input logic [IW-1:0] clr_idx,
   input logic clr_done,
   output logic [WORDS-1:0][WORD_SIZE-1:0] words,
   output logic [1:0] len,
   output logic locked,
   output logic valid
);
   logic [WORDS-1:0] mask;
   logic [WORDS-1:0] need;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         words <= '0;
         mask <= '0;
         len <= DEFAULT_LEN;
         locked <= 1'b0;
      end else begin
         if (wen) begin
            words[widx] <= wdata;
            mask[widx] <= 1'b1;
         end
         if (clr_wen) words[clr_idx] <= '0;
         if (cfg_wen) begin
            len <= cfg_len;
            mask <= '0;
         end
         if (clr_mask) mask <= '0;
         if (lock) locked <= 1'b1;
         if (clr_done) begin
            locked <= 1'b0;
            len <= DEFAULT_LEN;
         end
      end
   end
   always_comb begin
      need = '0;
      for (int i = 0; i < WORDS; i++) need[i] = i < klen_words(len);
   end
   assign valid = &(mask | ~need);
endmodule

// File: rtl/key_store.sv
// key_store: multi-slot AES key store with request arbitration, lock, sequenced zeroize and registered read port.
module key_store import key_store_pkg::*; #(
   parameter int SLOTS = 4,
   parameter int WORDS = 8,
   parameter int WORD_SIZE = 32,
   parameter logic [1:0] DEFAULT_LEN = KLEN_256,
   localparam int SW = $clog2(SLOTS),
   localparam int IW = $clog2(WORDS)
) (
   input logic clk,
   input logic rst,
   input logic [SW-1:0] slot,
   input logic [IW-1:0] widx,
   input logic wen,
   input logic [WORD_SIZE-1:0] wdata,
   input logic cfg_wen,
   input logic [1:0] cfg_len,
   input logic lock_req,
   input logic zero_req,
   input logic [SW-1:0] rd_slot,
   output logic [WORDS*WORD_SIZE-1:0] key_out,
   output logic [1:0] key_len,
   output logic key_valid,
   output logic busy,
   output logic wr_err
);
   state_t state;
   logic [SW-1:0] zslot, next_zslot;
   logic [IW-1:0] cnt;
   logic [WORDS-1:0][WORD_SIZE-1:0] s_words [SLOTS];
   logic [1:0] s_len [SLOTS];
   logic [SLOTS-1:0] s_locked, s_valid;
   logic [WORDS-1:0][WORD_SIZE-1:0] rd_words;
   logic wen_ok, cfg_ok, lock_ok, do_zero, do_cfg, do_lock, do_wr, multi, err, last, next_busy;
   assign wen_ok = !busy && !s_locked[slot] && int'(widx) < klen_words(s_len[slot]);
   assign cfg_ok = !busy && !s_locked[slot] && klen_legal(cfg_len, WORDS);
   assign lock_ok = !busy && s_valid[slot];
   // Strict priority: only the highest asserted request is ever considered.
   assign do_zero = zero_req && !busy;
   assign do_cfg = !zero_req && cfg_wen && cfg_ok;
   assign do_lock = !zero_req && !cfg_wen && lock_req && lock_ok;
   assign do_wr = !zero_req && !cfg_wen && !lock_req && wen && wen_ok;
   assign multi = (zero_req && (cfg_wen || lock_req || wen)) || (cfg_wen && (lock_req || wen)) || (lock_req && wen);
   assign err = multi || ((zero_req || cfg_wen || lock_req || wen) && !(do_zero || do_cfg || do_lock || do_wr));
   assign last = cnt == IW'(WORDS - 1);
   assign next_busy = do_zero || (busy && !last);
   assign next_zslot = do_zero ? slot : zslot;
   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      logic sel, zsel;
      assign sel = slot == SW'(g);
      assign zsel = busy && zslot == SW'(g);
      key_slot #(.WORDS(WORDS), .WORD_SIZE(WORD_SIZE), .DEFAULT_LEN(DEFAULT_LEN)) u_slot (
         .clk(clk),
         .rst(rst),
         .wen(do_wr && sel),
         .widx(widx),
         .wdata(wdata),
         .cfg_wen(do_cfg && sel),
         .cfg_len(cfg_len),
         .lock(do_lock && sel),
         .clr_mask(do_zero && sel),
         .clr_wen(zsel),
         .clr_idx(cnt),
         .clr_done(zsel && last),
         .words(s_words[g]),
         .len(s_len[g]),
         .locked(s_locked[g]),
         .valid(s_valid[g])
      );
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         zslot <= '0;
         cnt <= '0;
         busy <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= err;
         if (state == ST_IDLE) begin
            if (do_zero) begin
               state <= ST_ZERO;
               busy <= 1'b1;
               zslot <= slot;
               cnt <= '0;
            end
         end else if (last) begin
            state <= ST_IDLE;
            busy <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
   always_comb begin
      rd_words = '0;
      for (int i = 0; i < WORDS; i++) rd_words[WORDS-1-i] = i < klen_words(s_len[rd_slot]) ? s_words[rd_slot][i] : '0;
   end
   // key_valid looks ahead at busy so it falls on the same edge busy rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_out <= '0;
         key_len <= DEFAULT_LEN;
         key_valid <= 1'b0;
      end else begin
         key_out <= rd_words;
         key_len <= s_len[rd_slot];
         key_valid <= s_valid[rd_slot] && !(next_busy && next_zslot == rd_slot);
      end
   end
endmodule

// File: tb/tb_key_store.sv
// tb_key_store: directed vector table plus randomized traffic checked against an array-based key store model.
module tb_key_store;
   import key_store_pkg::*;
   localparam int SLOTS = 4;
   localparam int WORDS = 8;
   localparam int WS = 32;
   localparam int DEF = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] slot, rd_slot, cfg_len;
   logic [2:0] widx;
   logic wen, cfg_wen, lock_req, zero_req;
   logic [31:0] wdata;
   logic [255:0] key_out;
   logic [1:0] key_len;
   logic key_valid, busy, wr_err;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   key_store #(.SLOTS(SLOTS), .WORDS(WORDS), .WORD_SIZE(WS), .DEFAULT_LEN(2'd2)) dut (
      .clk(clk), .rst(rst), .slot(slot), .widx(widx), .wen(wen), .wdata(wdata),
      .cfg_wen(cfg_wen), .cfg_len(cfg_len), .lock_req(lock_req), .zero_req(zero_req),
      .rd_slot(rd_slot), .key_out(key_out), .key_len(key_len), .key_valid(key_valid),
      .busy(busy), .wr_err(wr_err)
   );
   logic [31:0] m_w [SLOTS][WORDS];
   bit m_mask [SLOTS][WORDS];
   int m_len [SLOTS];
   bit m_lock [SLOTS];
   int m_left, m_zs;
   logic [255:0] e_key;
   int e_len;
   bit e_valid, e_busy, e_err;
   typedef struct {
      bit z, c, l, w;
      logic [1:0] sl;
      logic [2:0] wi;
      logic [31:0] wd;
      logic [1:0] cl, rs;
      bit ev, ee, eb;
      int elen;
      int ck;
   } rec_t;
   rec_t tbl[$];
   function automatic rec_t r(bit z, bit c, bit l, bit w, int sl, int wi, logic [31:0] wd, int cl, int rs,
                              bit ev, bit ee, bit eb, int elen, int ck);
      rec_t x;
      x.z = z; x.c = c; x.l = l; x.w = w;
      x.sl = 2'(sl); x.wi = 3'(wi); x.wd = wd; x.cl = 2'(cl); x.rs = 2'(rs);
      x.ev = ev; x.ee = ee; x.eb = eb; x.elen = elen; x.ck = ck;
      return x;
   endfunction
   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic bit m_valid(int s);
      for (int i = 0; i < 4 + 2 * m_len[s]; i++) if (!m_mask[s][i]) return 0;
      return 1;
   endfunction
   task automatic m_reset();
      for (int s = 0; s < SLOTS; s++) begin
         for (int i = 0; i < WORDS; i++) begin
            m_w[s][i] = 0;
            m_mask[s][i] = 0;
         end
         m_len[s] = DEF;
         m_lock[s] = 0;
      end
      m_left = 0;
      m_zs = 0;
   endtask
   // Advances the model across one clock edge using the currently driven inputs.
   task automatic m_step();
      int n;
      int nreq;
      bit bz, err, v;
      n = 4 + 2 * m_len[slot];
      nreq = int'(zero_req) + int'(cfg_wen) + int'(lock_req) + int'(wen);
      bz = m_left > 0;
      err = nreq > 1;
      e_key = '0;
      for (int i = 0; i < 4 + 2 * m_len[rd_slot]; i++) e_key[255 - 32 * i -: 32] = m_w[rd_slot][i];
      e_len = m_len[rd_slot];
      v = m_valid(rd_slot);
      if (bz) begin
         m_w[m_zs][WORDS - m_left] = 0;
         m_left--;
         if (m_left == 0) begin
            m_lock[m_zs] = 0;
            m_len[m_zs] = DEF;
         end
      end
      if (zero_req) begin
         if (bz) err = 1;
         else begin
            m_zs = slot;
            m_left = WORDS;
            for (int i = 0; i < WORDS; i++) m_mask[slot][i] = 0;
         end
      end else if (cfg_wen) begin
         if (bz || m_lock[slot] || cfg_len == 3 || 4 + 2 * cfg_len > WORDS) err = 1;
         else begin
            m_len[slot] = cfg_len;
            for (int i = 0; i < WORDS; i++) m_mask[slot][i] = 0;
         end
      end else if (lock_req) begin
         if (bz || !m_valid(slot)) err = 1;
         else m_lock[slot] = 1;
      end else if (wen) begin
         if (bz || m_lock[slot] || widx >= n) err = 1;
         else begin
            m_w[slot][widx] = wdata;
            m_mask[slot][widx] = 1;
         end
      end
      e_busy = m_left > 0;
      e_valid = v && !(e_busy && m_zs == rd_slot);
      e_err = err;
   endtask
   task automatic step(bit z, bit c, bit l, bit w, logic [1:0] sl, logic [2:0] wi, logic [31:0] wd,
                       logic [1:0] cl, logic [1:0] rs);
      zero_req = z; cfg_wen = c; lock_req = l; wen = w;
      slot = sl; widx = wi; wdata = wd; cfg_len = cl; rd_slot = rs;
      m_step();
      @(posedge clk);
      @(negedge clk);
      chk("key_out", key_out, e_key);
      chk("key_len", key_len, e_len);
      chk("key_valid", key_valid, e_valid);
      chk("busy", busy, e_busy);
      chk("wr_err", wr_err, e_err);
   endtask
   initial begin
      logic [255:0] ka;
      ka = {32'h0, 32'h11111111, 32'h22222222, 32'h33333333, 128'h0};
      zero_req = 0; cfg_wen = 0; lock_req = 0; wen = 0;
      slot = 0; widx = 0; wdata = 0; cfg_len = 0; rd_slot = 0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_key_out", key_out, 0);
      chk("rst_key_len", key_len, 2);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_err", wr_err, 0);
      rst = 0;
      // slot 1 as a 128-bit key
      tbl.push_back(r(0,1,0,0, 1,0,0,0,1, 0,0,0,2,0));
      for (int i = 0; i < 4; i++) tbl.push_back(r(0,0,0,1, 1,i,32'h11111111 * i,0,1, 0,0,0,0,0));
      tbl.push_back(r(0,0,0,0, 1,0,0,0,1, 1,0,0,0,1));
      // slot 0 at default 256-bit length
      for (int i = 0; i < 7; i++) tbl.push_back(r(0,0,0,1, 0,i,32'hA0000000 + i,0,0, 0,0,0,2,0));
      tbl.push_back(r(0,0,0,0, 0,0,0,0,0, 0,0,0,2,0));
      tbl.push_back(r(0,0,0,1, 0,7,32'hA0000007,0,0, 0,0,0,2,0));
      tbl.push_back(r(0,0,0,0, 0,0,0,0,0, 1,0,0,2,0));
      tbl.push_back(r(0,1,0,0, 0,0,0,0,0, 1,0,0,2,0));
      tbl.push_back(r(0,0,0,1, 0,6,32'hBAD00006,0,0, 0,1,0,0,0));
      tbl.push_back(r(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
      // lock slot 2, then rejected writes/cfg and a lock of invalid slot 3
      tbl.push_back(r(0,1,0,0, 2,0,0,0,2, 0,0,0,2,0));
      for (int i = 0; i < 4; i++) tbl.push_back(r(0,0,0,1, 2,i,32'hC0000000 + i,0,2, 0,0,0,0,0));
      tbl.push_back(r(0,0,1,0, 2,0,0,0,2, 1,0,0,0,0));
      tbl.push_back(r(0,0,0,1, 2,0,32'hDEADBEEF,0,2, 1,1,0,0,0));
      tbl.push_back(r(0,1,0,0, 2,0,0,1,2, 1,1,0,0,0));
      tbl.push_back(r(0,0,1,0, 3,0,0,0,2, 1,1,0,0,0));
      // zeroize locked slot 2: busy for exactly WORDS cycles
      tbl.push_back(r(1,0,0,0, 2,0,0,0,2, 0,0,1,0,0));
      tbl.push_back(r(0,0,0,1, 0,0,32'h12345678,0,2, 0,1,1,0,0));
      for (int i = 0; i < 6; i++) tbl.push_back(r(0,0,0,0, 0,0,0,0,2, 0,0,1,0,0));
      tbl.push_back(r(0,0,0,0, 0,0,0,0,2, 0,0,0,0,0));
      tbl.push_back(r(0,0,0,0, 0,0,0,0,2, 0,0,0,2,2));
      tbl.push_back(r(0,0,0,1, 2,0,32'h0BADF00D,0,2, 0,0,0,2,0));
      // zero_req with a simultaneous wen, then an illegal length code
      tbl.push_back(r(1,0,0,1, 1,0,32'hFFFFFFFF,0,1, 0,1,1,0,0));
      for (int i = 0; i < 7; i++) tbl.push_back(r(0,0,0,0, 0,0,0,0,1, 0,0,1,0,0));
      tbl.push_back(r(0,0,0,0, 0,0,0,0,1, 0,0,0,0,0));
      tbl.push_back(r(0,1,0,0, 0,0,0,3,0, 0,1,0,0,0));
      tbl.push_back(r(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
      foreach (tbl[k]) begin
         step(tbl[k].z, tbl[k].c, tbl[k].l, tbl[k].w, tbl[k].sl, tbl[k].wi, tbl[k].wd, tbl[k].cl, tbl[k].rs);
         chk($sformatf("tbl%0d_valid", k), key_valid, tbl[k].ev);
         chk($sformatf("tbl%0d_err", k), wr_err, tbl[k].ee);
         chk($sformatf("tbl%0d_busy", k), busy, tbl[k].eb);
         chk($sformatf("tbl%0d_len", k), key_len, tbl[k].elen);
         if (tbl[k].ck == 1) chk("key128_layout", key_out, ka);
         if (tbl[k].ck == 2) chk("zeroized_key", key_out, 0);
      end
      // reset in the middle of a zeroize
      step(1,0,0,0, 0,0,0,0,0);
      step(0,0,0,0, 0,0,0,0,0);
      step(0,0,0,0, 0,0,0,0,0);
      rst = 1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_key_out", key_out, 0);
      chk("midrst_key_len", key_len, 2);
      chk("midrst_key_valid", key_valid, 0);
      chk("midrst_wr_err", wr_err, 0);
      m_reset();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 8; i++) step(0,0,0,1, 3,3'(i),$urandom,0,3);
      step(0,0,0,0, 0,0,0,0,3);
      chk("post_rst_valid", key_valid, 1);
      for (int k = 0; k < 600; k++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) == 1, 2'($urandom), 3'($urandom), $urandom, 2'($urandom), 2'($urandom));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/key_store.md
Name: key_store

Overview:
- Multi-slot, word-addressed key store feeding the AES core.
- Successor to the single 4-word key register. Adds:
  - several independent key slots;
  - per-slot key length (128/192/256);
  - written-word tracking and a valid flag;
  - a lock against overwrite;
  - a sequenced zeroization engine.
- Sits between the bus register block and the AES key-expansion input.

Parameters:
- SLOTS, 4, number of independent key slots.
- WORDS, 8, maximum words per slot; must be >= 4.
- WORD_SIZE, 32, bits per word.
- DEFAULT_LEN, 2, key-length code per slot after reset or zeroize (0=128, 1=192, 2=256).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- slot  in  $clog2(SLOTS)  target slot for wen/cfg_wen/lock_req/zero_req
- widx  in  $clog2(WORDS)  word index for wen
- wen  in  1  write wdata to slot/widx
- wdata  in  WORD_SIZE  write data
- cfg_wen  in  1  set key length of slot to cfg_len
- cfg_len  in  2  key-length code
- lock_req  in  1  lock slot
- zero_req  in  1  start zeroization of slot
- rd_slot  in  $clog2(SLOTS)  slot presented on key_out
- key_out  out  WORDS*WORD_SIZE  key of rd_slot, word 0 in most-significant position
- key_len  out  2  length code of rd_slot
- key_valid  out  1  rd_slot fully written and not being zeroized
- busy  out  1  zeroization in progress
- wr_err  out  1  one-cycle pulse: the previous cycle's request was rejected

Behaviour:
- Word count per length code: n = 4 + 2*len. Valid codes: 0, 1, 2. Code 3 is illegal. A code with n > WORDS is illegal.
- Per-slot state:
  - words[WORDS];
  - mask[WORDS] (word-written bits);
  - len[2];
  - locked;
  - valid = all of mask[0..n-1] set.
- Reset values:
  - all words 0, masks 0, locked 0, len DEFAULT_LEN;
  - FSM in IDLE;
  - key_out 0, key_len DEFAULT_LEN, key_valid 0, busy 0, wr_err 0.
- One request per cycle. Priority is zero_req > cfg_wen > lock_req > wen. Any lower-priority request asserted in the same cycle is dropped and sets wr_err.
- wen is accepted when all hold:
  - not busy;
  - slot not locked;
  - widx < n(slot).
  - On acceptance: words[widx] <= wdata and mask[widx] <= 1. Rewriting a word is legal.
  - Otherwise the request is dropped and wr_err is set.
- cfg_wen is accepted when not busy, slot not locked, and cfg_len is legal.
  - On acceptance: len <= cfg_len and mask <= 0; word contents are untouched.
  - Otherwise wr_err.
- lock_req is accepted when not busy and the slot is valid. It sets locked. A lock on an already-locked slot is accepted silently. Otherwise wr_err.
- Zeroize FSM, states IDLE and ZERO:
  - IDLE --zero_req--> ZERO. On that edge: latch zslot <= slot, cnt <= 0, mask[zslot] <= 0.
  - In ZERO: words[zslot][cnt] <= 0 and cnt++ each cycle; busy = 1.
  - At cnt == WORDS-1: locked <= 0, len <= DEFAULT_LEN, return to IDLE.
  - busy is high for exactly WORDS cycles. Zeroization clears locked slots.
  - zero_req while busy is dropped and sets wr_err.
  - Writes to any slot while busy are rejected. Slots are not independently writable during zeroize.
- wr_err is registered and high the cycle after a rejected request.
- Read path has 1-cycle registered latency:
  - key_out word i (bits [(WORDS-i)*WORD_SIZE-1 : (WORDS-1-i)*WORD_SIZE]) <= words[rd_slot][i] if i < n, else 0.
  - key_len <= len[rd_slot].
  - key_valid <= valid[rd_slot] & ~(next-state busy & zslot == rd_slot). key_valid therefore drops in the same cycle busy rises.
- A write and a read of the same slot in the same cycle: key_out shows the old data, and the new data one cycle later.
- rst mid-zeroize: immediate return to reset values. Reset is itself a full clear.

Decomposition:
- Package key_store_pkg holds:
  - localparams KLEN_128=0, KLEN_192=1, KLEN_256=2;
  - function klen_words(len) returning 4+2*len;
  - function klen_legal(len, WORDS);
  - state enum {ST_IDLE, ST_ZERO}.
- Sub-module key_slot: one slot's words, mask, len, locked and valid, with write, cfg, lock and clear-word strobes.
- key_store instantiates SLOTS copies of key_slot and contains the arbitration, the zeroize FSM and the read mux.

Test Plan:
- Reset, then write words 0-3 of slot 1 with len=0 (wdata = 0x11111111·i) -> key_valid=1 at rd_slot=1 one cycle after the last write. key_out top 128 bits = w0..w3, lower bits = 0.
- Slot 0 at default len 2: write 7 of 8 words -> key_valid=0. Write the 8th word -> key_valid=1. A wen with widx=6 after cfg_len=0 -> wr_err pulse, no data change.
- Lock a valid slot 2, then wen and cfg_wen to slot 2 -> two wr_err pulses, key unchanged. lock_req on invalid slot 3 -> wr_err.
- zero_req on locked slot 2 -> busy high for exactly 8 cycles. key_valid falls with busy. Afterwards all words 0, locked=0, key_len=2. A wen during busy -> wr_err.
- zero_req and wen asserted in the same cycle -> zeroize starts, write dropped, wr_err=1. cfg_len=3 -> wr_err, len unchanged.
- Assert rst at cycle 3 of a zeroize -> busy=0 and all outputs at reset values immediately. Normal writes work afterward.
